// File: rtl/tlu_trig_ctrl.sv
// Trigger sequencer: forms a masked/vetoed coincidence from discriminator VALIDs,
// pulses the enabled DUT trigger lines, runs the busy handshake, numbers and timestamps triggers.
module tlu_trig_ctrl #(
  parameter int N_CH  = 6,
  parameter int N_DUT = 4
) (
  input  logic             CLK40,
  input  logic             RST_N,
  input  logic             EN,
  input  logic [N_CH-1:0]  CH_VALID,
  input  logic [N_CH-1:0]  CH_EN_MASK,
  input  logic [N_CH-1:0]  CH_VETO_MASK,
  input  logic [N_DUT-1:0] DUT_EN_MASK,
  input  logic [N_DUT-1:0] DUT_BUSY,
  input  logic [7:0]       TRIG_LEN,
  input  logic [15:0]      BUSY_TIMEOUT,
  output logic [N_DUT-1:0] DUT_TRIGGER,
  output logic             TRIG_STB,
  output logic [31:0]      TRIG_ID,
  output logic [31:0]      TRIG_TIME,
  output logic [15:0]      SKIP_CNT,
  output logic             TIMEOUT_ERR,
  output logic [1:0]       STATE
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_TRIG     = 2'd1,
    S_WAIT_ACK = 2'd2,
    S_WAIT_REL = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] ts_q;
  logic [31:0] trig_cnt_q;
  logic [31:0] trig_id_q;
  logic [31:0] trig_time_q;
  logic [15:0] skip_q;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic [7:0]  len_cnt_q, len_cnt_d;
  logic        hit_prev_q;
  logic        trig_stb_q;
  logic        timeout_err_q;

  logic hit, coin, accept, skip;
  logic pulse_done, handshake_en, acked, released, timeout, ack_timeout;

  // A channel present in both masks needs VALID high and low at once, so it blocks HIT.
  assign hit = EN & (|CH_EN_MASK) & (&(CH_VALID | ~CH_EN_MASK)) & ~(|(CH_VALID & CH_VETO_MASK));
  assign coin   = hit & ~hit_prev_q;
  assign accept = coin & (state_q == S_IDLE);
  assign skip   = coin & (state_q != S_IDLE);

  // Busy handshake: after the pulse every enabled DUT must raise BUSY (ack) within
  // BUSY_TIMEOUT cycles; then all enabled DUTs must drop BUSY (release) before IDLE.
  assign pulse_done   = (len_cnt_q >= TRIG_LEN);
  assign handshake_en = (BUSY_TIMEOUT != 16'd0) & (|DUT_EN_MASK);
  assign acked        = &(DUT_BUSY | ~DUT_EN_MASK);
  assign released     = ~|(DUT_BUSY & DUT_EN_MASK);
  assign timeout      = ({1'b0, to_cnt_q} + 17'd1) >= {1'b0, BUSY_TIMEOUT};
  assign ack_timeout  = EN & (state_q == S_WAIT_ACK) & ~acked & timeout;

  always_ff @(posedge CLK40 or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!EN) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:     if (accept) state_d = S_TRIG;
        S_TRIG:     if (pulse_done) state_d = handshake_en ? S_WAIT_ACK : S_IDLE;
        S_WAIT_ACK: begin
          if (acked)        state_d = S_WAIT_REL;
          else if (timeout) state_d = S_IDLE;
        end
        S_WAIT_REL: if (released) state_d = S_IDLE;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    DUT_TRIGGER = '0;
    if ((state_q == S_TRIG) && EN) begin
      DUT_TRIGGER = DUT_EN_MASK;
    end
    STATE = state_q;
  end

  // Both counters sit at zero outside their state, so entry always starts from zero.
  assign len_cnt_d = (state_q == S_TRIG)     ? len_cnt_q + 8'd1 : 8'd0;
  assign to_cnt_d  = (state_q == S_WAIT_ACK) ? to_cnt_q + 16'd1 : 16'd0;

  always_ff @(posedge CLK40 or negedge RST_N) begin
    if (!RST_N) begin
      ts_q          <= 32'd0;
      hit_prev_q    <= 1'b0;
      trig_cnt_q    <= 32'd0;
      trig_id_q     <= 32'd0;
      trig_time_q   <= 32'd0;
      trig_stb_q    <= 1'b0;
      skip_q        <= 16'd0;
      timeout_err_q <= 1'b0;
      len_cnt_q     <= 8'd0;
      to_cnt_q      <= 16'd0;
    end else begin
      ts_q       <= ts_q + 32'd1;
      hit_prev_q <= hit;
      trig_stb_q <= accept;
      len_cnt_q  <= len_cnt_d;
      to_cnt_q   <= to_cnt_d;
      if (accept) begin
        trig_id_q   <= trig_cnt_q;
        trig_cnt_q  <= trig_cnt_q + 32'd1;
        trig_time_q <= ts_q;
      end
      if (skip && (skip_q != 16'hFFFF)) begin
        skip_q <= skip_q + 16'd1;
      end
      if (ack_timeout) begin
        timeout_err_q <= 1'b1;
      end
    end
  end

  assign TRIG_STB    = trig_stb_q;
  assign TRIG_ID     = trig_id_q;
  assign TRIG_TIME   = trig_time_q;
  assign SKIP_CNT    = skip_q;
  assign TIMEOUT_ERR = timeout_err_q;

endmodule

// File: tb/tb_tlu_trig_ctrl.sv
// Bench for tlu_trig_ctrl: directed scenarios plus randomized traffic, all checked
// against a cycle-level behavioural model and an expected-trigger queue.
module tb_tlu_trig_ctrl;
  localparam int N_CH  = 6;
  localparam int N_DUT = 4;

  logic             clk40 = 1'b0;
  logic             rst_n = 1'b1;
  logic             en = 1'b0;
  logic [N_CH-1:0]  ch_valid = '0;
  logic [N_CH-1:0]  ch_en_mask = '0;
  logic [N_CH-1:0]  ch_veto_mask = '0;
  logic [N_DUT-1:0] dut_en_mask = '0;
  logic [N_DUT-1:0] dut_busy = '0;
  logic [7:0]       trig_len = '0;
  logic [15:0]      busy_timeout = '0;
  logic [N_DUT-1:0] dut_trigger;
  logic             trig_stb;
  logic [31:0]      trig_id;
  logic [31:0]      trig_time;
  logic [15:0]      skip_cnt;
  logic             timeout_err;
  logic [1:0]       state;

  tlu_trig_ctrl #(.N_CH(N_CH), .N_DUT(N_DUT)) dut (
    .CLK40(clk40), .RST_N(rst_n), .EN(en),
    .CH_VALID(ch_valid), .CH_EN_MASK(ch_en_mask), .CH_VETO_MASK(ch_veto_mask),
    .DUT_EN_MASK(dut_en_mask), .DUT_BUSY(dut_busy),
    .TRIG_LEN(trig_len), .BUSY_TIMEOUT(busy_timeout),
    .DUT_TRIGGER(dut_trigger), .TRIG_STB(trig_stb), .TRIG_ID(trig_id),
    .TRIG_TIME(trig_time), .SKIP_CNT(skip_cnt), .TIMEOUT_ERR(timeout_err),
    .STATE(state)
  );

  // clock / watchdog
  always #5 clk40 = ~clk40;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_vec = 0;
  int n_err = 0;

  // behavioural model: phase 0 idle, 1 pulsing, 2 awaiting ack, 3 awaiting release
  int          m_state;
  int          m_pulse_left;
  int          m_ack_left;
  logic        m_hit_prev;
  logic [31:0] m_ts;
  logic [31:0] m_cnt;
  logic [31:0] m_id;
  logic [31:0] m_time;
  logic [15:0] m_skip;
  logic        m_terr;
  logic        m_stb;
  logic [63:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_pulse_left = 0; m_ack_left = 0; m_hit_prev = 1'b0;
    m_ts = '0; m_cnt = '0; m_id = '0; m_time = '0; m_skip = '0;
    m_terr = 1'b0; m_stb = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic hit, coin;
    hit = en && (ch_en_mask != 0)
             && ((ch_valid & ch_en_mask) == ch_en_mask)
             && ((ch_valid & ch_veto_mask) == 0);
    coin = hit && !m_hit_prev;
    m_hit_prev = hit;
    m_stb = 1'b0;
    if (coin && m_state != 0 && m_skip != 16'hFFFF) m_skip++;
    if (!en) begin
      m_state = 0;
    end else begin
      case (m_state)
        0: if (coin) begin
          exp_q.push_back({m_ts, m_cnt});
          m_state = 1; m_stb = 1'b1; m_id = m_cnt; m_time = m_ts;
          m_cnt = m_cnt + 32'd1;
          m_pulse_left = int'(trig_len) + 1;
        end
        1: begin
          m_pulse_left--;
          if (m_pulse_left == 0) begin
            if (busy_timeout != 0 && dut_en_mask != 0) begin
              m_state = 2; m_ack_left = int'(busy_timeout);
            end else begin
              m_state = 0;
            end
          end
        end
        2: begin
          if ((dut_busy & dut_en_mask) == dut_en_mask) begin
            m_state = 3;
          end else begin
            m_ack_left--;
            if (m_ack_left == 0) begin
              m_terr = 1'b1; m_state = 0;
            end
          end
        end
        default: if ((dut_busy & dut_en_mask) == 0) m_state = 0;
      endcase
    end
    m_ts = m_ts + 32'd1;
  endtask

  // scoreboard
  task automatic check_all();
    logic [N_DUT-1:0] exp_trig;
    logic [63:0]      rec;
    exp_trig = (m_state == 1 && en) ? dut_en_mask : '0;
    chk("state", state, m_state);
    chk("dut_trigger", dut_trigger, exp_trig);
    chk("trig_stb", trig_stb, m_stb);
    chk("trig_id", trig_id, m_id);
    chk("trig_time", trig_time, m_time);
    chk("skip_cnt", skip_cnt, m_skip);
    chk("timeout_err", timeout_err, m_terr);
    if (trig_stb === 1'b1) begin
      n_vec++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL stb_queue: observed strobe id %0h expected no strobe", trig_id);
      end
      if (exp_q.size() != 0) begin
        rec = exp_q.pop_front();
        chk("trig_record", {trig_time, trig_id}, rec);
      end
    end
  endtask

  // driver tasks
  task automatic tick();
    model_step();
    @(posedge clk40);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_dut_trigger", dut_trigger, 0);
    chk("rst_trig_stb", trig_stb, 0);
    chk("rst_trig_id", trig_id, 0);
    chk("rst_trig_time", trig_time, 0);
    chk("rst_skip_cnt", skip_cnt, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_state", state, 0);
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic run_until_state(input int target);
    for (int i = 0; i < 300 && m_state != target; i++) tick();
    chk("reach_state", m_state, target);
  endtask

  initial begin
    int n_pulse;
    int n_stb;
    int n_wait;

    @(posedge clk40);
    do_reset();

    // T1: basic trigger at timestamp 100, 3-cycle pulse, no handshake
    ch_en_mask = 6'b000011; ch_veto_mask = '0; dut_en_mask = 4'b0101;
    trig_len = 8'd2; busy_timeout = 16'd0; en = 1'b1;
    for (int i = 0; i < 200 && m_ts != 32'd100; i++) tick();
    ch_valid = 6'b000011;
    n_pulse = 0; n_stb = 0;
    tick();
    chk("t1_id", trig_id, 0);
    chk("t1_time", trig_time, 100);
    for (int i = 0; i < 9; i++) begin
      if (dut_trigger == 4'b0101) n_pulse++;
      if (trig_stb) n_stb++;
      if (i == 3) ch_valid = '0;
      tick();
    end
    chk("t1_pulse_len", n_pulse, 3);
    chk("t1_stb_count", n_stb, 1);
    chk("t1_idle", state, 0);

    // T2: veto blocks, then clean coincidence is accepted
    do_reset();
    ch_veto_mask = 6'b000100;
    ch_valid = 6'b000111;
    n_stb = 0;
    for (int i = 0; i < 3; i++) begin tick(); if (trig_stb) n_stb++; end
    chk("t2_vetoed", n_stb, 0);
    ch_valid = '0; tick();
    ch_valid = 6'b000011; tick();
    chk("t2_stb", trig_stb, 1);
    chk("t2_id", trig_id, 0);
    ch_valid = '0;
    repeat (5) tick();

    // T3: ack timeout with only one of two DUTs answering
    do_reset();
    ch_veto_mask = '0; busy_timeout = 16'd10; dut_en_mask = 4'b0011;
    dut_busy = 4'b0001; trig_len = 8'd0;
    ch_valid = 6'b000011; tick(); ch_valid = '0;
    n_wait = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (state == 2'd2) n_wait++; end
    chk("t3_wait_cycles", n_wait, 10);
    chk("t3_timeout_err", timeout_err, 1);
    chk("t3_idle", state, 0);
    dut_busy = '0; busy_timeout = 16'd0;
    ch_valid = 6'b000011; tick(); ch_valid = '0;
    chk("t3_next_id", trig_id, 1);
    repeat (4) tick();

    // T4: full handshake with 4 coincidence edges while busy
    do_reset();
    busy_timeout = 16'd200; dut_en_mask = 4'b0011; trig_len = 8'd1; dut_busy = '0;
    ch_valid = 6'b000011; tick(); ch_valid = '0;
    run_until_state(2);
    repeat (3) tick();
    dut_busy = 4'b0011;
    for (int k = 0; k < 50; k++) begin
      ch_valid = ((k % 12) == 2 || (k % 12) == 3) ? 6'b000011 : 6'b000000;
      tick();
    end
    ch_valid = '0;
    chk("t4_skip", skip_cnt, 4);
    chk("t4_held", state, 3);
    dut_busy = '0; tick();
    chk("t4_idle", state, 0);

    // T5: EN drop in WAIT_REL, then async reset mid-pulse
    ch_valid = 6'b000011; tick(); ch_valid = '0;
    run_until_state(2);
    dut_busy = 4'b0011; tick();
    chk("t5_wait_rel", state, 3);
    en = 1'b0; tick();
    chk("t5_en_idle", state, 0);
    chk("t5_en_trig", dut_trigger, 0);
    en = 1'b1; dut_busy = '0; tick();
    trig_len = 8'd10; busy_timeout = 16'd0;
    ch_valid = 6'b000011; tick(); ch_valid = '0;
    repeat (3) tick();
    chk("t5_pulse_live", dut_trigger, 4'b0011);
    do_reset();

    // T6: skip saturation and trigger-id wrap from preloaded counters
    busy_timeout = 16'd200; trig_len = 8'd0; dut_en_mask = 4'b0011;
    force dut.skip_q = 16'hFFFD;
    force dut.trig_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.skip_q;
    release dut.trig_cnt_q;
    m_skip = 16'hFFFD; m_cnt = 32'hFFFF_FFFF;
    ch_valid = 6'b000011; tick(); ch_valid = '0;
    chk("t6_id_max", trig_id, 32'hFFFF_FFFF);
    run_until_state(2);
    dut_busy = 4'b0011; tick();
    for (int k = 0; k < 12; k++) begin
      ch_valid = ((k % 3) == 0) ? 6'b000011 : 6'b000000;
      tick();
    end
    chk("t6_skip_sat", skip_cnt, 16'hFFFF);
    ch_valid = '0; dut_busy = '0;
    repeat (2) tick();
    ch_valid = 6'b000011; tick(); ch_valid = '0;
    chk("t6_id_wrap", trig_id, 0);
    run_until_state(2);
    dut_busy = 4'b0011; tick(); dut_busy = '0; tick();

    // T7: randomized traffic
    do_reset();
    for (int seg = 0; seg < 6; seg++) begin
      en = 1'b0; ch_valid = '0; tick();
      ch_en_mask   = N_CH'($urandom_range(0, 63));
      ch_veto_mask = ($urandom_range(0, 3) == 0) ? N_CH'($urandom_range(0, 63)) : '0;
      dut_en_mask  = N_DUT'($urandom_range(0, 15));
      trig_len     = 8'($urandom_range(0, 4));
      busy_timeout = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
      en = 1'b1;
      for (int c = 0; c < 300; c++) begin
        ch_valid = ($urandom_range(0, 2) == 0) ? (ch_en_mask | N_CH'($urandom_range(0, 63)))
                                               : N_CH'($urandom_range(0, 63));
        dut_busy = N_DUT'($urandom_range(0, 15));
        en = ($urandom_range(0, 40) != 0);
        tick();
      end
    end

    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
